// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
//
// Serializes a latched PAT_W-bit pattern MSB-first onto a one-bit stream.
// The pattern repeats rpt times. An optional run of gap zero bits separates
// the repetitions. All outputs are registered, so no input reaches an output
// within the same cycle.
//
// Ports:
//   clk      clock, all state changes on posedge
//   reset    synchronous, active-high reset
//   start    run request, sampled only in IDLE
//   pattern  bits to send, MSB first (latched on accepted start)
//   rpt      number of repetitions, 0 means ignore start (latched)
//   gap      zero bits between repetitions (latched)
//   outbit   serial data
//   frame    high while outbit carries a pattern bit
//   busy     high in SEND, GAP and DONE
//   done     one-cycle pulse after the last pattern bit

module serial_pattern_tx #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] rpt,
    input  logic [GAP_W-1:0] gap,
    output logic             outbit,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BitW = $clog2(PAT_W);
    localparam logic [BitW-1:0] LastBit = BitW'(PAT_W - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   shift_q, shift_d;
    logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               outbit_q, outbit_d;
    logic               frame_q, frame_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rem_q     <= '0;
            gap_cnt_q <= '0;
            pat_q     <= '0;
            gap_q     <= '0;
            outbit_q  <= 1'b0;
            frame_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rem_q     <= rem_d;
            gap_cnt_q <= gap_cnt_d;
            pat_q     <= pat_d;
            gap_q     <= gap_d;
            outbit_q  <= outbit_d;
            frame_q   <= frame_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath update. shift_q[MSB] is the bit on outbit
    // during the current SEND cycle; bit_cnt_q==0 marks the last bit.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        rem_d     = rem_q;
        gap_cnt_d = gap_cnt_q;
        pat_d     = pat_q;
        gap_d     = gap_q;
        unique case (state_q)
            StIdle: begin
                if (start && (rpt != '0)) begin
                    pat_d     = pattern;
                    gap_d     = gap;
                    rem_d     = rpt;
                    shift_d   = pattern;
                    bit_cnt_d = LastBit;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (bit_cnt_q == '0) begin
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end else if (gap_q == '0) begin
                        // Back-to-back repetition, no bubble.
                        shift_d   = pat_q;
                        bit_cnt_d = LastBit;
                    end else begin
                        gap_cnt_d = gap_q;
                        state_d   = StGap;
                    end
                end else begin
                    shift_d   = {shift_q[PAT_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q - BitW'(1);
                end
            end
            StGap: begin
                if (gap_cnt_q == GAP_W'(1)) begin
                    shift_d   = pat_q;
                    bit_cnt_d = LastBit;
                    state_d   = StSend;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are computed from the next state and registered, giving the
    // one-cycle start-to-first-bit latency with no input-to-output path.
    always_comb begin
        outbit_d = 1'b0;
        frame_d  = 1'b0;
        busy_d   = (state_d != StIdle);
        done_d   = (state_d == StDone);
        if (state_d == StSend) begin
            outbit_d = shift_d[PAT_W-1];
            frame_d  = 1'b1;
        end
    end

    assign outbit = outbit_q;
    assign frame  = frame_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx: table of runs with hand-computed
// per-cycle streams, plus hand-written reset sequences.

module tb_serial_pattern_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] rpt;
    logic [3:0] gap;
    logic       outbit;
    logic       frame;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    serial_pattern_tx #(
        .PAT_W(4),
        .CNT_W(4),
        .GAP_W(4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .pattern(pattern),
        .rpt    (rpt),
        .gap    (gap),
        .outbit (outbit),
        .frame  (frame),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One run: busy for len cycles after the start edge; ob/fr/dn hold the
    // expected outbit/frame/done for cycles 1..len, cycle 1 in bit len-1.
    typedef struct {
        string       name;
        logic [3:0]  pat;
        logic [3:0]  rpt;
        logic [3:0]  gap;
        bit          noisy;
        int          len;
        logic [31:0] ob;
        logic [31:0] fr;
        logic [31:0] dn;
    } vec_t;

    vec_t vecs[$];

    // Compare {outbit, frame, busy, done} against the expected bundle.
    task automatic chk(input string name, input int cyc, input logic [3:0] exp);
        logic [3:0] act;
        act = {outbit, frame, busy, done};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got {ob,fr,bz,dn}=%b want %b", name, cyc, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0] exp;
        @(negedge clk);
        pattern = v.pat;
        rpt     = v.rpt;
        gap     = v.gap;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < v.len; k++) begin
            exp = {v.ob[v.len-1-k], v.fr[v.len-1-k], 1'b1, v.dn[v.len-1-k]};
            chk(v.name, k + 1, exp);
            if (v.noisy) begin
                // Restart attempts and input changes while busy (incl. DONE).
                start   = 1'b1;
                pattern = ~v.pat;
                rpt     = 4'd15;
                gap     = 4'd7;
            end
            @(posedge clk);
            #1;
        end
        chk(v.name, v.len + 1, 4'b0000);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk(v.name, v.len + 2 + k, 4'b0000);
        end
    endtask

    initial begin
        logic [7:0] mid_ob;
        logic [7:0] mid_fr;
        vec_t       fresh;

        reset   = 1'b1;
        start   = 1'b0;
        pattern = 4'b0000;
        rpt     = 4'd0;
        gap     = 4'd0;

        // Reset for 2 cycles, then idle for 10.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("reset", k, 4'b0000);
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("idle", k, 4'b0000);
        end

        vecs.push_back('{"single", 4'b1001, 4'd1, 4'd0, 1'b0, 5,
                         32'b10010, 32'b11110, 32'b00001});
        vecs.push_back('{"b2b", 4'b1001, 4'd3, 4'd0, 1'b0, 13,
                         32'b1001100110010, 32'b1111111111110, 32'b0000000000001});
        vecs.push_back('{"gap3", 4'b1011, 4'd2, 4'd3, 1'b0, 12,
                         32'b101100010110, 32'b111100011110, 32'b000000000001});
        vecs.push_back('{"gap1", 4'b1110, 4'd2, 4'd1, 1'b0, 10,
                         32'b1110011100, 32'b1111011110, 32'b0000000001});
        vecs.push_back('{"rpt0", 4'b1111, 4'd0, 4'd0, 1'b0, 0,
                         32'b0, 32'b0, 32'b0});
        vecs.push_back('{"noisy", 4'b1011, 4'd2, 4'd1, 1'b1, 10,
                         32'b1011010110, 32'b1111011110, 32'b0000000001});

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during the second bit of the second repetition.
        mid_ob = 8'b10010010;
        mid_fr = 8'b11110011;
        @(negedge clk);
        pattern = 4'b1001;
        rpt     = 4'd4;
        gap     = 4'd2;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("midrun", k + 1, {mid_ob[7-k], mid_fr[7-k], 1'b1, 1'b0});
            if (k < 7) begin
                @(posedge clk);
                #1;
            end
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_rst", 9, 4'b0000);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("midrun_after", 10 + k, 4'b0000);
        end

        fresh = '{"fresh", 4'b0110, 4'd1, 4'd0, 1'b0, 5,
                  32'b01100, 32'b11110, 32'b00001};
        run_vec(fresh);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
